// File: rtl/rev_mac_if.sv
`default_nettype none
// ============================================================================
// Module      : rev_mac_if
// Description : Host and command bundle for rev_mac_engine.
//               master : host / SPI-slave side (drives strobes and commands)
//               slave  : engine side (drives read data, status, accumulator)
//               Buffer write : host_wen, host_waddr, host_wdata ({b,a})
//               Buffer read  : host_ren, host_raddr -> host_rdata, host_rvalid
//               Command      : cmd_valid, cmd, cmd_count -> cmd_ready
//               Status       : busy, done, acc, err
// Revision    : 1.0 - initial release
// ============================================================================
interface rev_mac_if #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int ACCW  = 2*DW + $clog2(DEPTH)
);
    logic              host_wen;
    logic [AW-1:0]     host_waddr;
    logic [2*DW-1:0]   host_wdata;
    logic              host_ren;
    logic [AW-1:0]     host_raddr;
    logic [2*DW-1:0]   host_rdata;
    logic              host_rvalid;
    logic              cmd_valid;
    logic [1:0]        cmd;
    logic [AW:0]       cmd_count;
    logic              cmd_ready;
    logic              busy;
    logic              done;
    logic [ACCW-1:0]   acc;
    logic              err;

    modport master (
        output host_wen, host_waddr, host_wdata,
        output host_ren, host_raddr,
        input  host_rdata, host_rvalid,
        output cmd_valid, cmd, cmd_count,
        input  cmd_ready, busy, done, acc, err
    );

    modport slave (
        input  host_wen, host_waddr, host_wdata,
        input  host_ren, host_raddr,
        output host_rdata, host_rvalid,
        input  cmd_valid, cmd, cmd_count,
        output cmd_ready, busy, done, acc, err
    );
endinterface
`default_nettype wire

// File: rtl/rev_mac_engine.sv
`default_nettype none
// ============================================================================
// Module      : rev_mac_engine
// Description : Reversible multiply-accumulate engine. The host loads {b,a}
//               operand pairs into a DEPTH-entry buffer. A forward pass adds
//               a*b over entries 0..N-1 into acc; a reverse pass subtracts
//               them in the order N-1..0 and sets the sticky err flag if acc
//               does not return to the value captured at the last forward
//               accept. Arithmetic is modulo 2^ACCW.
//               Ports : clk, rst_n (async, active-low)
//                       bus    (rev_mac_if.slave: host port, command, status)
// Revision    : 1.0 - initial release
// ============================================================================
module rev_mac_engine #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int ACCW  = 2*DW + $clog2(DEPTH)
) (
    input  wire         clk,
    input  wire         rst_n,
    rev_mac_if.slave    bus
);

    localparam logic [1:0]  c_cmd_fwd = 2'b01;
    localparam logic [1:0]  c_cmd_rev = 2'b10;
    localparam logic [1:0]  c_cmd_clr = 2'b11;
    localparam logic [AW:0] c_depth   = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Operand buffer (not reset; contents survive reset)
    logic [2*DW-1:0] r_mem [DEPTH];

    logic [AW-1:0]   r_idx;        // address being issued this RUN cycle
    logic [AW:0]     r_remain;     // issues still to perform
    logic            r_dir;        // 1 = reverse pass
    logic            r_v1;         // r_rd holds a valid entry
    logic            r_v2;         // r_prod holds a valid product
    logic [2*DW-1:0] r_rd;
    logic [2*DW-1:0] r_prod;
    logic [ACCW-1:0] r_acc;
    logic [ACCW-1:0] r_base;
    logic            r_err;
    logic [2*DW-1:0] r_hrdata;
    logic            r_hrvalid;

    logic            w_idle;
    logic            w_accept;
    logic            w_start;
    logic            w_clear;
    logic            w_issue;
    logic            w_busy;
    logic            w_done;
    logic [AW:0]     w_count_n;
    logic [ACCW-1:0] w_prod_ext;

    assign w_idle     = (r_state == S_IDLE);
    assign w_accept   = bus.cmd_valid & w_idle;
    assign w_start    = w_accept & ((bus.cmd == c_cmd_fwd) | (bus.cmd == c_cmd_rev));
    assign w_clear    = w_accept & (bus.cmd == c_cmd_clr);
    assign w_count_n  = (bus.cmd_count > c_depth) ? c_depth : bus.cmd_count;
    assign w_issue    = (r_state == S_RUN);
    assign w_prod_ext = {{(ACCW-2*DW){1'b0}}, r_prod};

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A zero-length pass still walks through DRAIN so that its
                // done pulse lands one cycle after the accept edge.
                if (w_start) begin
                    w_state_nxt = (w_count_n == '0) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (r_remain == (AW+1)'(1)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                // Once nothing is left in the read stage, the product stage
                // (if valid) accumulates on this edge and the pass is over.
                if (!r_v1) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Buffer write port: host only while idle
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (bus.host_wen && w_idle) begin
            r_mem[bus.host_waddr] <= bus.host_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Issue counter, pipeline, accumulator, host read port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_remain  <= '0;
            r_dir     <= 1'b0;
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_rd      <= '0;
            r_prod    <= '0;
            r_acc     <= '0;
            r_base    <= '0;
            r_err     <= 1'b0;
            r_hrdata  <= '0;
            r_hrvalid <= 1'b0;
        end else begin
            r_v1 <= w_issue;
            r_v2 <= r_v1;

            if (w_issue) begin
                r_rd <= r_mem[r_idx];
            end
            if (r_v1) begin
                r_prod <= {{DW{1'b0}}, r_rd[DW-1:0]} * {{DW{1'b0}}, r_rd[2*DW-1:DW]};
            end
            if (r_v2) begin
                r_acc <= r_dir ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);
            end

            if (w_start) begin
                r_dir    <= (bus.cmd == c_cmd_rev);
                r_remain <= w_count_n;
                // Reverse walks from the last entry down; N=DEPTH wraps to DEPTH-1.
                r_idx    <= (bus.cmd == c_cmd_rev) ? (w_count_n[AW-1:0] - AW'(1)) : '0;
                if (bus.cmd == c_cmd_fwd) begin
                    r_base <= r_acc;
                end
            end else if (w_issue) begin
                r_remain <= r_remain - (AW+1)'(1);
                r_idx    <= r_dir ? (r_idx - AW'(1)) : (r_idx + AW'(1));
            end

            if (w_clear) begin
                r_acc  <= '0;
                r_base <= '0;
                r_err  <= 1'b0;
            end else if ((r_state == S_DONE) && r_dir) begin
                r_err <= r_err | (r_acc != r_base);
            end

            // Same-cycle write to the read address returns the old contents.
            r_hrvalid <= bus.host_ren & w_idle;
            if (bus.host_ren && w_idle) begin
                r_hrdata <= r_mem[bus.host_raddr];
            end
        end
    end

    assign bus.host_rdata  = r_hrdata;
    assign bus.host_rvalid = r_hrvalid;
    assign bus.cmd_ready   = w_idle;
    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.acc         = r_acc;
    assign bus.err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rev_mac_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_rev_mac_engine
// Description : Directed self-checking bench for rev_mac_engine
//               (DW=8, DEPTH=16, ACCW=20). Inputs change 1 time unit after
//               the rising edge; outputs are sampled at the same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rev_mac_engine;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int ACCW  = 20;

    localparam logic [1:0] c_nop = 2'b00;
    localparam logic [1:0] c_fwd = 2'b01;
    localparam logic [1:0] c_rev = 2'b10;
    localparam logic [1:0] c_clr = 2'b11;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    rev_mac_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

    rev_mac_engine #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [AW-1:0] addr, input logic [2*DW-1:0] data);
        bus.host_wen   = 1'b1;
        bus.host_waddr = addr;
        bus.host_wdata = data;
        tick();
        bus.host_wen   = 1'b0;
    endtask

    task automatic host_read(input logic [AW-1:0] addr, output logic [2*DW-1:0] data,
                             output logic valid);
        bus.host_ren   = 1'b1;
        bus.host_raddr = addr;
        tick();
        bus.host_ren   = 1'b0;
        data  = bus.host_rdata;
        valid = bus.host_rvalid;
    endtask

    task automatic send_cmd(input logic [1:0] c, input logic [AW:0] n);
        bus.cmd       = c;
        bus.cmd_count = n;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // Issues a command and returns cycles from the accept edge to the done
    // pulse (-1 if it never arrived) and the number of busy cycles seen.
    task automatic run_pass(input logic [1:0] c, input logic [AW:0] n,
                            output int lat, output int busy_cyc);
        lat      = -1;
        busy_cyc = 0;
        send_cmd(c, n);
        if (bus.busy) busy_cyc++;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [2*DW-1:0] d;
        logic            v;
        tests++; if (bus.acc !== 20'd0) begin fails++; $display("FAIL reset_acc: got %0d expected 0", bus.acc); end
        tests++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
            fails++; $display("FAIL reset_status: ready=%b busy=%b done=%b err=%b expected 1 0 0 0",
                              bus.cmd_ready, bus.busy, bus.done, bus.err);
        end
        tests++; if (bus.host_rvalid !== 1'b0 || bus.host_rdata !== 16'h0000) begin
            fails++; $display("FAIL reset_rd: rvalid=%b rdata=%h expected 0 0000", bus.host_rvalid, bus.host_rdata);
        end
        host_write(4'd9, 16'hBEEF);
        host_read(4'd9, d, v);
        tests++; if (v !== 1'b1 || d !== 16'hBEEF) begin
            fails++; $display("FAIL reset_readback: rvalid=%b rdata=%h expected 1 beef", v, d);
        end
    endtask

    task automatic test_forward();
        int lat, bc;
        host_write(4'd0, 16'h0503);
        host_write(4'd1, 16'hFFFF);
        host_write(4'd2, 16'h0700);
        host_write(4'd3, 16'h0A0A);
        run_pass(c_fwd, 5'd4, lat, bc);
        tests++; if (lat !== 6) begin fails++; $display("FAIL fwd_latency: got %0d expected 6", lat); end
        tests++; if (bc !== 6) begin fails++; $display("FAIL fwd_busy_cycles: got %0d expected 6", bc); end
        tests++; if (bus.acc !== 20'd65140) begin fails++; $display("FAIL fwd_acc: got %0d expected 65140", bus.acc); end
        tests++; if (bus.cmd_ready !== 1'b0) begin fails++; $display("FAIL fwd_ready_in_done: got %b expected 0", bus.cmd_ready); end
        tick();
        tests++; if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            fails++; $display("FAIL fwd_after_done: done=%b ready=%b expected 0 1", bus.done, bus.cmd_ready);
        end
    endtask

    task automatic test_reverse();
        int lat, bc;
        run_pass(c_rev, 5'd4, lat, bc);
        tests++; if (lat !== 6) begin fails++; $display("FAIL rev_latency: got %0d expected 6", lat); end
        tick();
        tests++; if (bus.acc !== 20'd0 || bus.err !== 1'b0) begin
            fails++; $display("FAIL rev_clean: acc=%0d err=%b expected 0 0", bus.acc, bus.err);
        end
        run_pass(c_fwd, 5'd4, lat, bc);
        tick();
        tests++; if (bus.acc !== 20'd65140) begin fails++; $display("FAIL rev_refwd_acc: got %0d expected 65140", bus.acc); end
        host_write(4'd1, 16'h0202);
        run_pass(c_rev, 5'd4, lat, bc);
        tick();
        tests++; if (bus.acc !== 20'd65021 || bus.err !== 1'b1) begin
            fails++; $display("FAIL rev_dirty: acc=%0d err=%b expected 65021 1", bus.acc, bus.err);
        end
        send_cmd(c_clr, 5'd0);
        tests++; if (bus.acc !== 20'd0 || bus.err !== 1'b0 || bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            fails++; $display("FAIL clear: acc=%0d err=%b done=%b ready=%b expected 0 0 0 1",
                              bus.acc, bus.err, bus.done, bus.cmd_ready);
        end
    endtask

    task automatic test_full_wrap();
        int lat, bc;
        for (int i = 0; i < DEPTH; i++) host_write(AW'(i), 16'hFFFF);
        run_pass(c_fwd, 5'd16, lat, bc);
        tick();
        tests++; if (lat !== 18) begin fails++; $display("FAIL full_latency: got %0d expected 18", lat); end
        tests++; if (bus.acc !== 20'd1040400) begin fails++; $display("FAIL full_acc1: got %0d expected 1040400", bus.acc); end
        run_pass(c_fwd, 5'd16, lat, bc);
        tick();
        tests++; if (bus.acc !== 20'd1032224) begin fails++; $display("FAIL full_wrap: got %0d expected 1032224", bus.acc); end
        send_cmd(c_clr, 5'd0);
        run_pass(c_fwd, 5'd20, lat, bc);
        tick();
        tests++; if (lat !== 18 || bc !== 18) begin
            fails++; $display("FAIL count20_timing: lat=%0d busy=%0d expected 18 18", lat, bc);
        end
        tests++; if (bus.acc !== 20'd1040400) begin fails++; $display("FAIL count20_acc: got %0d expected 1040400", bus.acc); end
    endtask

    task automatic test_busy_ignore();
        int lat, bc;
        int got_done;
        logic [2*DW-1:0] d;
        logic            v;
        run_pass(c_fwd, 5'd0, lat, bc);
        tests++; if (lat !== 1) begin fails++; $display("FAIL zero_latency: got %0d expected 1", lat); end
        tests++; if (bus.acc !== 20'd1040400) begin fails++; $display("FAIL zero_acc: got %0d expected 1040400", bus.acc); end
        tick();
        send_cmd(c_fwd, 5'd16);
        tick();
        bus.host_wen   = 1'b1;
        bus.host_waddr = 4'd5;
        bus.host_wdata = 16'h0101;
        bus.host_ren   = 1'b1;
        bus.host_raddr = 4'd5;
        bus.cmd        = c_clr;
        bus.cmd_valid  = 1'b1;
        tick();
        bus.host_wen  = 1'b0;
        bus.host_ren  = 1'b0;
        bus.cmd_valid = 1'b0;
        tests++; if (bus.host_rvalid !== 1'b0) begin fails++; $display("FAIL busy_rvalid: got %b expected 0", bus.host_rvalid); end
        got_done = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.done) begin got_done = 1; break; end
            tick();
        end
        tests++; if (got_done !== 1) begin fails++; $display("FAIL busy_pass_done: got %0d expected 1", got_done); end
        tests++; if (bus.acc !== 20'd1032224) begin fails++; $display("FAIL busy_cmd_ignored: acc=%0d expected 1032224", bus.acc); end
        tick();
        host_read(4'd5, d, v);
        tests++; if (v !== 1'b1 || d !== 16'hFFFF) begin
            fails++; $display("FAIL busy_write_dropped: rvalid=%b rdata=%h expected 1 ffff", v, d);
        end
        // Read and write the same address in one idle cycle: old data returns.
        bus.host_wen   = 1'b1;
        bus.host_waddr = 4'd7;
        bus.host_wdata = 16'h1234;
        bus.host_ren   = 1'b1;
        bus.host_raddr = 4'd7;
        tick();
        bus.host_wen = 1'b0;
        bus.host_ren = 1'b0;
        tests++; if (bus.host_rdata !== 16'hFFFF) begin fails++; $display("FAIL rw_collision_old: got %h expected ffff", bus.host_rdata); end
        host_read(4'd7, d, v);
        tests++; if (d !== 16'h1234) begin fails++; $display("FAIL rw_collision_new: got %h expected 1234", d); end
    endtask

    task automatic test_reset_midpass();
        int lat, bc;
        logic [2*DW-1:0] d;
        logic            v;
        run_pass(c_rev, 5'd1, lat, bc);
        tick();
        tests++; if (bus.acc !== 20'd967199 || bus.err !== 1'b1) begin
            fails++; $display("FAIL rev1_err: acc=%0d err=%b expected 967199 1", bus.acc, bus.err);
        end
        send_cmd(c_fwd, 5'd16);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        tests++; if (bus.acc !== 20'd0 || bus.err !== 1'b0) begin
            fails++; $display("FAIL midreset_acc: acc=%0d err=%b expected 0 0", bus.acc, bus.err);
        end
        tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            fails++; $display("FAIL midreset_status: busy=%b done=%b ready=%b expected 0 0 1",
                              bus.busy, bus.done, bus.cmd_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
        host_read(4'd0, d, v);
        tests++; if (v !== 1'b1 || d !== 16'hFFFF) begin
            fails++; $display("FAIL midreset_buffer: rvalid=%b rdata=%h expected 1 ffff", v, d);
        end
    endtask

    task automatic test_write_with_cmd();
        int got_lat;
        bus.host_wen   = 1'b1;
        bus.host_waddr = 4'd0;
        bus.host_wdata = 16'h0404;
        bus.cmd        = c_fwd;
        bus.cmd_count  = 5'd1;
        bus.cmd_valid  = 1'b1;
        tick();
        bus.host_wen  = 1'b0;
        bus.cmd_valid = 1'b0;
        got_lat = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (bus.done) begin got_lat = i; break; end
        end
        tests++; if (got_lat !== 3) begin fails++; $display("FAIL wr_cmd_latency: got %0d expected 3", got_lat); end
        tests++; if (bus.acc !== 20'd16) begin fails++; $display("FAIL wr_cmd_acc: got %0d expected 16", bus.acc); end
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        rst_n          = 1'b0;
        bus.host_wen   = 1'b0;
        bus.host_waddr = '0;
        bus.host_wdata = '0;
        bus.host_ren   = 1'b0;
        bus.host_raddr = '0;
        bus.cmd_valid  = 1'b0;
        bus.cmd        = c_nop;
        bus.cmd_count  = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_forward();
        test_reverse();
        test_full_wrap();
        test_busy_ignore();
        test_reset_midpass();
        test_write_with_cmd();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
